// File: rtl/riscv_defines.sv
// Shared RISC-V core definitions: CSR operation encoding plus the CSR port
// arbiter state type and wait-counter width.
package riscv_defines;

  typedef enum logic [1:0] {
    CSR_OP_NONE  = 2'b00,
    CSR_OP_WRITE = 2'b01,
    CSR_OP_SET   = 2'b10,
    CSR_OP_CLEAR = 2'b11
  } csr_op_t;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_RESP = 1'b1
  } arb_state_t;

  localparam int CSR_DBG_WAIT_W = 8;

endpackage

// File: rtl/riscv_csr_port_arbiter_chk.sv
// Protocol checker for the CSR port arbiter debug handshake; holds only
// assertions and is instantiated alongside the arbiter.
module riscv_csr_port_arbiter_chk (
  input logic clk,
  input logic rst_n,
  input logic dbg_req_i,
  input logic dbg_gnt_o,
  input logic dbg_rvalid_o
);

  // A debug request must be held until it is granted.
  property p_req_held_until_gnt;
    @(posedge clk) disable iff (!rst_n)
      (dbg_req_i && !dbg_gnt_o) |=> dbg_req_i;
  endproperty

  // Every grant produces a response in the following cycle.
  property p_rvalid_after_gnt;
    @(posedge clk) disable iff (!rst_n)
      dbg_gnt_o |=> dbg_rvalid_o;
  endproperty

  a_req_held_until_gnt : assert property (p_req_held_until_gnt)
    else $error("dbg_req_i dropped before dbg_gnt_o");

  a_rvalid_after_gnt : assert property (p_rvalid_after_gnt)
    else $error("dbg_rvalid_o missing after dbg_gnt_o");

endmodule

// File: rtl/riscv_csr_port_arbiter.sv
// Shares the CSR file port between the core pipeline and the debug unit.
// Optional macro CSR_ARB_FAIRNESS_EN adds a wait counter that forces debug priority.
module riscv_csr_port_arbiter
  import riscv_defines::*;
#(
  parameter int MAX_DBG_WAIT = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          core_csr_access_i,
  input  logic [11:0]   core_csr_addr_i,
  input  logic [31:0]   core_csr_wdata_i,
  input  csr_op_t       core_csr_op_i,
  output logic [31:0]   core_csr_rdata_o,
  output logic          core_stall_o,
  input  logic          dbg_req_i,
  input  logic          dbg_we_i,
  input  logic [11:0]   dbg_addr_i,
  input  logic [31:0]   dbg_wdata_i,
  output logic          dbg_gnt_o,
  output logic          dbg_rvalid_o,
  output logic [31:0]   dbg_rdata_o,
  input  logic          exc_busy_i,
  output logic          csr_access_o,
  output logic [11:0]   csr_addr_o,
  output logic [31:0]   csr_wdata_o,
  output csr_op_t       csr_op_o,
  input  logic [31:0]   csr_rdata_i
);

  if ((MAX_DBG_WAIT < 1) || (MAX_DBG_WAIT > 255)) begin : g_bad_max_wait
    $error("MAX_DBG_WAIT must lie in 1..255");
  end

  logic        grant_s;
  logic        force_s;
  arb_state_t  state_r;
  arb_state_t  state_nxt_s;
  logic [31:0] dbg_rdata_r;

`ifdef CSR_ARB_FAIRNESS_EN
  localparam logic [CSR_DBG_WAIT_W-1:0] MAX_WAIT_C  = CSR_DBG_WAIT_W'(MAX_DBG_WAIT);
  localparam logic [CSR_DBG_WAIT_W-1:0] WAIT_SAT_C  = {CSR_DBG_WAIT_W{1'b1}};
  localparam logic [CSR_DBG_WAIT_W-1:0] WAIT_ONE_C  = CSR_DBG_WAIT_W'(1);
  localparam logic [CSR_DBG_WAIT_W-1:0] WAIT_ZERO_C = CSR_DBG_WAIT_W'(0);

  logic [CSR_DBG_WAIT_W-1:0] wait_cnt_r;

  // Count refused debug cycles, saturating, cleared when debug wins the port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_r <= WAIT_ZERO_C;
    end else if (grant_s) begin
      wait_cnt_r <= WAIT_ZERO_C;
    end else if (dbg_req_i && (wait_cnt_r != WAIT_SAT_C)) begin
      wait_cnt_r <= wait_cnt_r + WAIT_ONE_C;
    end else begin
      wait_cnt_r <= wait_cnt_r;
    end
  end

  assign force_s      = (wait_cnt_r >= MAX_WAIT_C) && !exc_busy_i;
  assign core_stall_o = grant_s && core_csr_access_i;
`else
  // Strict core priority: debug only ever uses idle port cycles.
  assign force_s      = 1'b0;
  assign core_stall_o = 1'b0;
`endif

  assign grant_s = dbg_req_i && !exc_busy_i && (!core_csr_access_i || force_s);

  // Every grant leads to exactly one response cycle; a grant in RESP chains on.
  always_comb begin
    state_nxt_s = ARB_IDLE;
    case (state_r)
      ARB_IDLE: begin
        if (grant_s) begin
          state_nxt_s = ARB_RESP;
        end else begin
          state_nxt_s = ARB_IDLE;
        end
      end
      ARB_RESP: begin
        if (grant_s) begin
          state_nxt_s = ARB_RESP;
        end else begin
          state_nxt_s = ARB_IDLE;
        end
      end
      default: begin
        state_nxt_s = ARB_IDLE;
      end
    endcase
  end

  // State and captured debug read data; a write returns the pre-write value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ARB_IDLE;
      dbg_rdata_r <= 32'h0000_0000;
    end else begin
      state_r <= state_nxt_s;
      if (grant_s) begin
        dbg_rdata_r <= csr_rdata_i;
      end else begin
        dbg_rdata_r <= dbg_rdata_r;
      end
    end
  end

  // CSR port mux: debug on grant, otherwise the core passes straight through.
  always_comb begin
    csr_access_o = core_csr_access_i;
    csr_addr_o   = core_csr_addr_i;
    csr_wdata_o  = core_csr_wdata_i;
    csr_op_o     = core_csr_op_i;
    if (grant_s) begin
      csr_access_o = 1'b1;
      csr_addr_o   = dbg_addr_i;
      csr_wdata_o  = dbg_wdata_i;
      if (dbg_we_i) begin
        csr_op_o = CSR_OP_WRITE;
      end else begin
        csr_op_o = CSR_OP_NONE;
      end
    end else begin
      csr_access_o = core_csr_access_i;
      csr_addr_o   = core_csr_addr_i;
      csr_wdata_o  = core_csr_wdata_i;
      csr_op_o     = core_csr_op_i;
    end
  end

  assign core_csr_rdata_o = csr_rdata_i;
  assign dbg_gnt_o        = grant_s;
  assign dbg_rvalid_o     = (state_r == ARB_RESP);
  assign dbg_rdata_o      = dbg_rdata_r;

  riscv_csr_port_arbiter_chk u_chk (
    .clk          (clk),
    .rst_n        (rst_n),
    .dbg_req_i    (dbg_req_i),
    .dbg_gnt_o    (grant_s),
    .dbg_rvalid_o (dbg_rvalid_o)
  );

endmodule

// File: tb/tb_riscv_csr_port_arbiter.sv
// Scoreboard bench for riscv_csr_port_arbiter: stimulus queues expected grants
// and responses, a negedge monitor pops and compares them.
module tb_riscv_csr_port_arbiter;
  import riscv_defines::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        core_csr_access_i = 1'b0;
  logic [11:0] core_csr_addr_i = 12'h000;
  logic [31:0] core_csr_wdata_i = 32'h0;
  csr_op_t     core_csr_op_i = CSR_OP_NONE;
  logic [31:0] core_csr_rdata_o;
  logic        core_stall_o;
  logic        dbg_req_i = 1'b0;
  logic        dbg_we_i = 1'b0;
  logic [11:0] dbg_addr_i = 12'h000;
  logic [31:0] dbg_wdata_i = 32'h0;
  logic        dbg_gnt_o;
  logic        dbg_rvalid_o;
  logic [31:0] dbg_rdata_o;
  logic        exc_busy_i = 1'b0;
  logic        csr_access_o;
  logic [11:0] csr_addr_o;
  logic [31:0] csr_wdata_o;
  csr_op_t     csr_op_o;
  logic [31:0] csr_rdata_i;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    int          cyc;
    logic [11:0] addr;
    csr_op_t     op;
    logic [31:0] wdata;
    logic        stall;
  } gnt_exp_t;

  typedef struct {
    int          cyc;
    logic [31:0] data;
  } rv_exp_t;

  gnt_exp_t gnt_q[$];
  rv_exp_t  rv_q[$];

  logic [31:0] csr_mem [4096];

  riscv_csr_port_arbiter #(.MAX_DBG_WAIT(8)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .core_csr_access_i (core_csr_access_i),
    .core_csr_addr_i   (core_csr_addr_i),
    .core_csr_wdata_i  (core_csr_wdata_i),
    .core_csr_op_i     (core_csr_op_i),
    .core_csr_rdata_o  (core_csr_rdata_o),
    .core_stall_o      (core_stall_o),
    .dbg_req_i         (dbg_req_i),
    .dbg_we_i          (dbg_we_i),
    .dbg_addr_i        (dbg_addr_i),
    .dbg_wdata_i       (dbg_wdata_i),
    .dbg_gnt_o         (dbg_gnt_o),
    .dbg_rvalid_o      (dbg_rvalid_o),
    .dbg_rdata_o       (dbg_rdata_o),
    .exc_busy_i        (exc_busy_i),
    .csr_access_o      (csr_access_o),
    .csr_addr_o        (csr_addr_o),
    .csr_wdata_o       (csr_wdata_o),
    .csr_op_o          (csr_op_o),
    .csr_rdata_i       (csr_rdata_i)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Simple CSR file model behind the port.
  assign csr_rdata_i = csr_mem[csr_addr_o];

  always @(posedge clk) begin
    if (rst_n && csr_access_o) begin
      case (csr_op_o)
        CSR_OP_WRITE: csr_mem[csr_addr_o] <= csr_wdata_o;
        CSR_OP_SET:   csr_mem[csr_addr_o] <= csr_mem[csr_addr_o] | csr_wdata_o;
        CSR_OP_CLEAR: csr_mem[csr_addr_o] <= csr_mem[csr_addr_o] & ~csr_wdata_o;
        default: ;
      endcase
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: compare grants and responses against the scoreboard queues.
  always @(negedge clk) begin
    if (rst_n) begin
      if (dbg_gnt_o) begin
        if (gnt_q.size() == 0) begin
          check("unexpected_gnt", 64'(dbg_gnt_o), 64'd0);
        end else begin
          gnt_exp_t g;
          g = gnt_q.pop_front();
          check("gnt_cycle", 64'(cyc), 64'(g.cyc));
          check("gnt_port", {csr_access_o, csr_addr_o, csr_op_o, csr_wdata_o},
                {1'b1, g.addr, g.op, g.wdata});
          check("gnt_stall", 64'(core_stall_o), 64'(g.stall));
        end
      end else begin
        check("core_pass", {csr_access_o, csr_addr_o, csr_op_o, csr_wdata_o},
              {core_csr_access_i, core_csr_addr_i, core_csr_op_i, core_csr_wdata_i});
        check("core_rdata", 64'(core_csr_rdata_o), 64'(csr_rdata_i));
        check("no_stall", 64'(core_stall_o), 64'd0);
      end
      if (dbg_rvalid_o) begin
        if (rv_q.size() == 0) begin
          check("unexpected_rvalid", 64'(dbg_rvalid_o), 64'd0);
        end else begin
          rv_exp_t r;
          r = rv_q.pop_front();
          check("rvalid_cycle", 64'(cyc), 64'(r.cyc));
          check("rdata", 64'(dbg_rdata_o), 64'(r.data));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one debug access, holding the request until it is granted.
  task automatic dbg_access(input logic we, input logic [11:0] addr, input logic [31:0] wdata,
                            input int core_n, input int exc_n, input int exp_off,
                            input logic exp_stall, input logic [31:0] exp_rdata);
    int   start;
    int   i;
    logic got;
    start = cyc;
    gnt_q.push_back('{start + exp_off, addr, (we ? CSR_OP_WRITE : CSR_OP_NONE), wdata, exp_stall});
    rv_q.push_back('{start + exp_off + 1, exp_rdata});
    dbg_req_i = 1'b1;
    dbg_we_i = we;
    dbg_addr_i = addr;
    dbg_wdata_i = wdata;
    core_csr_addr_i = 12'h305;
    core_csr_op_i = CSR_OP_NONE;
    core_csr_wdata_i = 32'h0;
    got = 1'b0;
    i = 0;
    while (!got && (i <= 40)) begin
      core_csr_access_i = (i < core_n);
      exc_busy_i = (i < exc_n);
      @(negedge clk);
      if (dbg_gnt_o) begin
        got = 1'b1;
      end else begin
        tick();
        i++;
      end
    end
    if (!got) check("dbg_timeout", 64'd0, 64'd1);
    tick();
    dbg_req_i = 1'b0;
    exc_busy_i = 1'b0;
    core_csr_access_i = ((i + 1) < core_n);
  endtask

  initial begin
    for (int a = 0; a < 4096; a++) csr_mem[a] = 32'h0;
    csr_mem[12'hF10] = 32'h0000_0425;
    csr_mem[12'h300] = 32'h0000_1800;
    csr_mem[12'h342] = 32'h8000_000B;

    repeat (2) tick();
    check("rst_rvalid", 64'(dbg_rvalid_o), 64'd0);
    check("rst_rdata", 64'(dbg_rdata_o), 64'd0);
    check("rst_gnt", 64'(dbg_gnt_o), 64'd0);
    check("rst_stall", 64'(core_stall_o), 64'd0);
    rst_n = 1'b1;
    tick();

    // Core-only traffic.
    core_csr_access_i = 1'b1;
    core_csr_addr_i = 12'h341;
    core_csr_wdata_i = 32'h0000_1234;
    core_csr_op_i = CSR_OP_WRITE;
    tick();
    core_csr_addr_i = 12'h342;
    core_csr_wdata_i = 32'h0;
    core_csr_op_i = CSR_OP_NONE;
    tick();
    core_csr_access_i = 1'b0;
    tick();

    // Debug read, core idle.
    dbg_access(1'b0, 12'hF10, 32'h0, 0, 0, 0, 1'b0, 32'h0000_0425);
    tick();
    // Debug write while core busy for 3 cycles.
    dbg_access(1'b1, 12'h300, 32'h1, 3, 0, 3, 1'b0, 32'h0000_1800);
    tick();
    // Back-to-back reads.
    dbg_access(1'b0, 12'h341, 32'h0, 0, 0, 0, 1'b0, 32'h0000_1234);
    dbg_access(1'b0, 12'h342, 32'h0, 0, 0, 0, 1'b0, 32'h8000_000B);
    tick();
    // Exception busy blocks the grant for 2 cycles.
    dbg_access(1'b0, 12'hF10, 32'h0, 0, 2, 2, 1'b0, 32'h0000_0425);
    tick();
`ifdef CSR_ARB_FAIRNESS_EN
    dbg_access(1'b0, 12'hF10, 32'h0, 10, 0, 8, 1'b1, 32'h0000_0425);
`else
    dbg_access(1'b0, 12'hF10, 32'h0, 12, 0, 12, 1'b0, 32'h0000_0425);
`endif
    tick();
    core_csr_access_i = 1'b0;
    // Counter must have cleared: a short core burst delays debug normally.
    dbg_access(1'b0, 12'h342, 32'h0, 3, 0, 3, 1'b0, 32'h8000_000B);
    tick();

    // Reset between grant and response drops the response.
    gnt_q.push_back('{cyc, 12'h342, CSR_OP_NONE, 32'h0, 1'b0});
    dbg_req_i = 1'b1;
    dbg_we_i = 1'b0;
    dbg_addr_i = 12'h342;
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    dbg_req_i = 1'b0;
    tick();
    check("midrst_rvalid", 64'(dbg_rvalid_o), 64'd0);
    check("midrst_rdata", 64'(dbg_rdata_o), 64'd0);
    rst_n = 1'b1;
    tick();
    check("post_rst_rvalid", 64'(dbg_rvalid_o), 64'd0);
    tick();

    check("gnt_q_drained", 64'(gnt_q.size()), 64'd0);
    check("rv_q_drained", 64'(rv_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/riscv_csr_port_arbiter.md
Name: riscv_csr_port_arbiter

Overview:
Shares the single CSR file access port between the core pipeline (ID/EX CSR instructions) and the debug unit. Core accesses pass through with zero added latency. Debug accesses are granted in idle port cycles using a req/gnt/rvalid handshake, with the read data registered. The block sits between the ID stage / debug unit and the CSR register file.

Parameters:
MAX_DBG_WAIT, 8, cycles a pending debug request may be refused before forced priority (only with the optional feature); legal range 1..255.

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
core_csr_access_i  in  1  core CSR access this cycle
core_csr_addr_i  in  12  core CSR address
core_csr_wdata_i  in  32  core write data
core_csr_op_i  in  csr_op_t  core operation (NONE/WRITE/SET/CLEAR)
core_csr_rdata_o  out  32  read data to core (combinational from port)
core_stall_o  out  1  core access refused this cycle; ID must hold
dbg_req_i  in  1  debug request; held until gnt
dbg_we_i  in  1  1 = write, 0 = read
dbg_addr_i  in  12  debug CSR address
dbg_wdata_i  in  32  debug write data
dbg_gnt_o  out  1  debug request accepted this cycle
dbg_rvalid_o  out  1  debug response valid
dbg_rdata_o  out  32  debug read data (registered)
exc_busy_i  in  1  exception save/restore/cause write in progress
csr_access_o  out  1  to CSR file
csr_addr_o  out  12  to CSR file
csr_wdata_o  out  32  to CSR file
csr_op_o  out  csr_op_t  to CSR file
csr_rdata_i  in  32  from CSR file

Behaviour:
- Reset values: dbg_rvalid_o=0, dbg_rdata_o=0, wait counter=0, FSM=IDLE. Combinational outputs default to the core path: dbg_gnt_o=0, core_stall_o=0.
- FSM states:
  - IDLE: port free for debug.
  - RESP: debug response pending; lasts exactly one cycle.
- Grant condition, evaluated combinationally in IDLE or RESP: dbg_req_i && !exc_busy_i && (!core_csr_access_i || force).
  - force=0 without the optional feature.
- On grant:
  - csr_access_o=1, csr_addr_o=dbg_addr_i, csr_wdata_o=dbg_wdata_i, csr_op_o=WRITE if dbg_we_i else NONE.
  - dbg_gnt_o=1.
  - csr_rdata_i is captured into dbg_rdata_o; for writes it is the pre-write value.
  - Next state RESP; dbg_rvalid_o=1 in the following cycle only.
- Back-to-back debug: a new grant is allowed in the RESP cycle, so sustained throughput is 1 access/cycle.
- Without a grant: core_* signals pass through to csr_* and core_csr_rdata_o=csr_rdata_i.
- If a grant is forced while core_csr_access_i=1: core_stall_o=1, the core path is blocked (csr_op_o comes from debug), and core_csr_rdata_o is don't-care.
- exc_busy_i=1: no debug grant; the core path is unaffected.
- Debug deasserting dbg_req_i before gnt is illegal; behaviour is undefined, and an SVA assertion flags it.
- Reset mid-transaction: the pending rvalid is dropped and the FSM returns to IDLE.

Optional Feature:
CSR_ARB_FAIRNESS_EN:
- Defined:
  - An 8-bit wait counter increments each cycle that dbg_req_i=1 and gnt=0, saturating at 255, and clears on gnt.
  - force=1 when counter >= MAX_DBG_WAIT and !exc_busy_i.
- Undefined:
  - Strict core priority; core_stall_o is tied to 0.
  - No counter is present, and debug can starve indefinitely.

Decomposition:
- Add to the shared riscv_defines package: reuse csr_op_t; add arb_state_t {ARB_IDLE, ARB_RESP}; add CSR_DBG_WAIT_W=8.
- No sub-module is needed. The wait counter is inline (it would be a trivial sub-module).

Test Plan:
1. Core-only traffic, write 0x341 value 0x0000_1234, dbg_req_i=0 -> csr_* mirrors core each cycle, core_stall_o=0, dbg_gnt_o=0.
2. Debug read of 0xF10 with core idle, CSR file returns 0x0000_0425 -> gnt in cycle N, csr_op_o=NONE in cycle N, dbg_rvalid_o=1 with dbg_rdata_o=0x0000_0425 in cycle N+1 only.
3. Debug write of 0x300 data 0x1 while core busy for 3 cycles -> gnt in the 4th cycle, csr_op_o=WRITE, csr_wdata_o=0x1, rdata is the prior mstatus value.
4. Two back-to-back debug reads (0x341, 0x342) -> gnt in cycles N and N+1, rvalid in N+1 and N+2 with the correct data.
5. exc_busy_i=1 for 2 cycles with a debug request pending -> no gnt during those cycles, gnt on the first cycle after it drops.
6. With CSR_ARB_FAIRNESS_EN and MAX_DBG_WAIT=8, core busy continuously and debug requesting -> gnt plus core_stall_o=1 in cycle 9, counter cleared, core resumes in cycle 10. Without the macro: no gnt while the core is busy.
